// File: rtl/hex_disp_pkg.sv
// Shared constants and types for the hex display scan path.
package hex_disp_pkg;

  // Per-bit level of a deselected digit; anodes are active-low, so a blank
  // display is all ones.
  localparam logic DIGIT_SEL_OFF = 1'b1;

  // All segments off, for decoders that need a blank code.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam int DEF_NUM_DIGITS  = 4;
  localparam int DEF_REFRESH_DIV = 50000;
  localparam int DEF_GUARD       = 2;

  typedef enum logic {
    S_GUARD,
    S_DRIVE
  } scan_state_t;

endpackage

// File: rtl/refresh_divider.sv
// Digit-slot timer: cnt runs 0..REFRESH_DIV-1 and tick marks the last cycle
// of each slot.
module refresh_divider
  import hex_disp_pkg::*;
#(
  parameter int REFRESH_DIV = DEF_REFRESH_DIV
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  output logic [((REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1)-1:0] cnt,
  output logic                                                  tick
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(REFRESH_DIV - 1);

  assign tick = (cnt == TC);

  // Free-running slot counter, wrapping at terminal count.
  always_ff @(posedge clk) begin
    if (reset)      cnt <= '0;
    else if (tick)  cnt <= '0;
    else            cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/hex_digit_scanner.sv
// Time-multiplexed scan controller feeding a nibble-to-7-segment decoder.
// Values are committed only at frame boundaries; each slot opens with a
// blanked guard gap.
//
// Optional build macro HEX_SCAN_LEADING_ZERO_BLANK_EN: digits above the most
// significant non-zero nibble stay blanked for their whole slot.
//
// state   | meaning
// S_GUARD | start of slot, cnt < GUARD, all digits deselected
// S_DRIVE | rest of slot, selected digit driven
module hex_digit_scanner
  import hex_disp_pkg::*;
#(
  parameter int NUM_DIGITS  = DEF_NUM_DIGITS,
  parameter int REFRESH_DIV = DEF_REFRESH_DIV,
  parameter int GUARD       = DEF_GUARD
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    load,
  output logic [3:0]              nibble,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done
);

  localparam int VW = 4 * NUM_DIGITS;
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] TC       = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{DIGIT_SEL_OFF}};
  localparam scan_state_t RESET_STATE = (GUARD > 0) ? S_GUARD : S_DRIVE;

  logic [CW-1:0]   cnt;
  logic            tick;
  logic [IW-1:0]   idx;
  logic [VW-1:0]   disp_reg;
  logic [VW-1:0]   pend_reg;
  logic            pend_valid;
  scan_state_t     state;

  logic [CW-1:0]   cnt_nxt;
  logic [IW-1:0]   idx_nxt;
  logic            boundary;
  logic            commit;
  logic [VW-1:0]   disp_nxt;
  logic            show_nxt;
  scan_state_t     state_nxt;
  logic [NUM_DIGITS-1:0] sel_nxt;

  refresh_divider #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_div (
    .clk   (clk),
    .reset (reset),
    .cnt   (cnt),
    .tick  (tick)
  );

  // Next slot position, mirrored from the divider so the registered pins
  // line up with the (cnt, idx) they describe.
  always_comb begin
    cnt_nxt  = tick ? '0 : cnt + CW'(1);
    idx_nxt  = idx;
    if (tick) idx_nxt = (idx == LAST_IDX) ? '0 : idx + IW'(1);
    boundary = tick && (idx == LAST_IDX);
    commit   = boundary && (load || pend_valid);
    disp_nxt = disp_reg;
    if (boundary) begin
      if (load)            disp_nxt = value_in;
      else if (pend_valid) disp_nxt = pend_reg;
    end
  end

`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
  logic [IW-1:0] msd_reg;
  logic [IW-1:0] msd_nxt;

  function automatic logic [IW-1:0] msd_of(input logic [VW-1:0] v);
    logic [IW-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (v[4*i +: 4] != 4'h0) m = IW'(i);
    return m;
  endfunction

  // Most significant shown digit tracks the committed value.
  always_comb begin
    msd_nxt  = commit ? msd_of(disp_nxt) : msd_reg;
    show_nxt = (idx_nxt <= msd_nxt);
  end

  // msd register is updated together with disp_reg.
  always_ff @(posedge clk) begin
    if (reset) msd_reg <= '0;
    else       msd_reg <= msd_nxt;
  end
`else
  assign show_nxt = 1'b1;
`endif

  // Guard/drive transitions and the digit enable they imply next cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_GUARD: if (cnt_nxt == GUARD_C)     state_nxt = S_DRIVE;
      S_DRIVE: if (tick && (GUARD > 0))    state_nxt = S_GUARD;
      default:                             state_nxt = RESET_STATE;
    endcase
    sel_nxt = ((state_nxt == S_DRIVE) && show_nxt)
            ? ~(NUM_DIGITS'(1) << idx_nxt) : SEL_OFF;
  end

  // Scan FSM with registered pin outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RESET_STATE;
      idx        <= '0;
      nibble     <= 4'h0;
      digit_sel  <= SEL_OFF;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      nibble     <= disp_nxt[4*idx_nxt +: 4];
      digit_sel  <= sel_nxt;
      frame_done <= (idx_nxt == LAST_IDX) && (cnt_nxt == TC);
    end
  end

  // Load capture: off-boundary loads wait in pend_reg, boundary loads bypass it.
  always_ff @(posedge clk) begin
    if (reset) begin
      disp_reg   <= '0;
      pend_reg   <= '0;
      pend_valid <= 1'b0;
    end else begin
      disp_reg <= disp_nxt;
      if (boundary) begin
        pend_valid <= 1'b0;
      end else if (load) begin
        pend_reg   <= value_in;
        pend_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hex_digit_scanner.sv
// Bench for hex_digit_scanner (4 digits, 8-cycle slots, 2-cycle guard).
module tb_hex_digit_scanner;

  localparam int ND    = 4;
  localparam int RD    = 8;
  localparam int GD    = 2;
  localparam int FRAME = ND * RD;

  logic        clk;
  logic        reset;
  logic [15:0] value_in;
  logic        load;
  logic [3:0]  nibble;
  logic [3:0]  digit_sel;
  logic        frame_done;

  hex_digit_scanner #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .GUARD       (GD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .value_in   (value_in),
    .load       (load),
    .nibble     (nibble),
    .digit_sel  (digit_sel),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: cycle count since reset plus displayed/pending values.
  int          m_t     = 0;
  bit          m_known = 0;
  logic [15:0] m_disp  = '0;
  logic [15:0] m_pend  = '0;
  bit          m_pv    = 0;

  typedef struct {
    int          cyc;
    logic        ld;
    logic [15:0] val;
    logic        rst;
    logic        chk;
    logic [3:0]  sel;
    logic [3:0]  nib;
    logic        fd;
  } vec_t;

  vec_t vecs[$];

  function automatic int msd_of(input logic [15:0] d);
    int m = 0;
    for (int i = 0; i < ND; i++)
      if (((d >> (4*i)) & 16'hF) != 0) m = i;
    return m;
  endfunction

  function automatic logic [3:0] exp_sel(input int tt, input logic [15:0] d);
    int c = tt % RD;
    int i = (tt / RD) % ND;
    if (c < GD) return 4'hF;
`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
    if (i > msd_of(d)) return 4'hF;
`endif
    return 4'(~(1 << i));
  endfunction

  function automatic logic [3:0] exp_nib(input int tt, input logic [15:0] d);
    int i = (tt / RD) % ND;
    return 4'((d >> (4*i)) & 16'hF);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d: got %0h, expected %0h", nm, m_t, act, exp);
    end
  endtask

  // Mid-cycle: compare pins against the model.
  task automatic mid();
    @(negedge clk);
    if (m_known) begin
      chk("model digit_sel", 32'(digit_sel), 32'(exp_sel(m_t, m_disp)));
      chk("model nibble", 32'(nibble), 32'(exp_nib(m_t, m_disp)));
      chk("model frame_done", 32'(frame_done), 32'((m_t % FRAME) == FRAME - 1));
    end
  endtask

  // Drive inputs for the current cycle, take the edge, advance the model.
  task automatic step(input logic ld, input logic [15:0] v, input logic rst);
    load     = ld;
    value_in = v;
    reset    = rst;
    @(posedge clk);
    if (rst) begin
      m_t = 0; m_disp = '0; m_pend = '0; m_pv = 0; m_known = 1;
    end else begin
      if ((m_t % FRAME) == FRAME - 1) begin
        if (ld)        m_disp = v;
        else if (m_pv) m_disp = m_pend;
        m_pv = 0;
      end else if (ld) begin
        m_pend = v; m_pv = 1;
      end
      m_t++;
    end
  endtask

  task automatic add_in(input int c, input logic ld, input logic [15:0] v, input logic rst);
    vecs.push_back('{cyc: c, ld: ld, val: v, rst: rst, chk: 1'b0, sel: 4'h0, nib: 4'h0, fd: 1'b0});
  endtask

  task automatic add_chk(input int c, input logic [3:0] s, input logic [3:0] n, input logic f);
    vecs.push_back('{cyc: c, ld: 1'b0, val: 16'h0, rst: 1'b0, chk: 1'b1, sel: s, nib: n, fd: f});
  endtask

  // Reset, then run ncyc scenario cycles applying/checking the table.
  task automatic run_vecs(input int ncyc, input string tag);
    logic        ld, rst;
    logic [15:0] v;
    mid();
    step(1'b0, 16'h0, 1'b1);
    for (int i = 0; i < ncyc; i++) begin
      mid();
      ld = 1'b0; rst = 1'b0; v = 16'h0;
      foreach (vecs[k]) begin
        if (vecs[k].cyc == i) begin
          if (vecs[k].chk) begin
            chk({tag, " digit_sel"}, 32'(digit_sel), 32'(vecs[k].sel));
            chk({tag, " nibble"}, 32'(nibble), 32'(vecs[k].nib));
            chk({tag, " frame_done"}, 32'(frame_done), 32'(vecs[k].fd));
          end else begin
            ld  = vecs[k].ld;
            v   = vecs[k].val;
            rst = vecs[k].rst;
          end
        end
      end
      step(ld, v, rst);
    end
    vecs.delete();
  endtask

  initial begin
    logic        ld, rst;
    logic [15:0] v;
    reset    = 1'b1;
    load     = 1'b0;
    value_in = 16'h0;
    step(1'b0, 16'h0, 1'b1);

    // Idle scan, then A5C3 loaded mid-frame shows from the next frame.
    add_in(5, 1'b1, 16'hA5C3, 1'b0);
    add_chk(0, 4'hF, 4'h0, 1'b0);   add_chk(1, 4'hF, 4'h0, 1'b0);
    add_chk(2, 4'hE, 4'h0, 1'b0);   add_chk(7, 4'hE, 4'h0, 1'b0);
    add_chk(8, 4'hF, 4'h0, 1'b0);   add_chk(9, 4'hF, 4'h0, 1'b0);
    add_chk(10, 4'hD, 4'h0, 1'b0);  add_chk(15, 4'hD, 4'h0, 1'b0);
    add_chk(30, 4'h7, 4'h0, 1'b0);  add_chk(31, 4'h7, 4'h0, 1'b1);
    add_chk(32, 4'hF, 4'h3, 1'b0);  add_chk(34, 4'hE, 4'h3, 1'b0);
    add_chk(42, 4'hD, 4'hC, 1'b0);  add_chk(50, 4'hB, 4'h5, 1'b0);
    add_chk(58, 4'h7, 4'hA, 1'b0);  add_chk(63, 4'h7, 4'hA, 1'b1);
    add_chk(64, 4'hF, 4'h3, 1'b0);
    run_vecs(70, "a5c3");

    // Last load in a frame wins.
    add_in(10, 1'b1, 16'h1111, 1'b0);
    add_in(20, 1'b1, 16'h2222, 1'b0);
    add_chk(31, 4'h7, 4'h0, 1'b1);  add_chk(34, 4'hE, 4'h2, 1'b0);
    add_chk(42, 4'hD, 4'h2, 1'b0);  add_chk(50, 4'hB, 4'h2, 1'b0);
    add_chk(58, 4'h7, 4'h2, 1'b0);
    run_vecs(64, "lastwins");

    // Load on the boundary cycle bypasses and discards the pending value.
    add_in(12, 1'b1, 16'h1234, 1'b0);
    add_in(31, 1'b1, 16'hBEEF, 1'b0);
    add_chk(31, 4'h7, 4'h0, 1'b1);  add_chk(32, 4'hF, 4'hF, 1'b0);
    add_chk(34, 4'hE, 4'hF, 1'b0);  add_chk(42, 4'hD, 4'hE, 1'b0);
    add_chk(50, 4'hB, 4'hE, 1'b0);  add_chk(58, 4'h7, 4'hB, 1'b0);
    run_vecs(64, "boundary");

    // Reset mid-frame drops the pending load and restarts the scan.
    add_in(3, 1'b1, 16'hA5C3, 1'b0);
    add_in(17, 1'b0, 16'h0, 1'b1);
    add_chk(17, 4'hF, 4'h0, 1'b0);  add_chk(18, 4'hF, 4'h0, 1'b0);
    add_chk(20, 4'hE, 4'h0, 1'b0);  add_chk(49, 4'h7, 4'h0, 1'b1);
    add_chk(50, 4'hF, 4'h0, 1'b0);  add_chk(52, 4'hE, 4'h0, 1'b0);
    run_vecs(60, "midreset");

`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
    // Leading-zero blanking: 0042 shows two digits, 0000 only digit 0.
    add_in(5, 1'b1, 16'h0042, 1'b0);
    add_chk(34, 4'hE, 4'h2, 1'b0);  add_chk(42, 4'hD, 4'h4, 1'b0);
    add_chk(50, 4'hF, 4'h0, 1'b0);  add_chk(58, 4'hF, 4'h0, 1'b0);
    add_chk(63, 4'hF, 4'h0, 1'b1);
    add_in(70, 1'b1, 16'h0000, 1'b0);
    add_chk(98, 4'hE, 4'h0, 1'b0);  add_chk(106, 4'hF, 4'h0, 1'b0);
    add_chk(114, 4'hF, 4'h0, 1'b0); add_chk(122, 4'hF, 4'h0, 1'b0);
    run_vecs(130, "lzblank");
`endif

    // Random loads, boundary loads and occasional resets against the model.
    mid();
    step(1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      mid();
      ld  = ($urandom_range(0, 7) == 0);
      if (((m_t % FRAME) == FRAME - 1) && ($urandom_range(0, 1) == 1)) ld = 1'b1;
      v   = 16'($urandom);
      if ($urandom_range(0, 3) == 0) v = v & 16'h00FF;
      rst = ($urandom_range(0, 499) == 0);
      step(ld, v, rst);
    end
    mid();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
